seq_divider: RTL and testbench

//  Sequential signed radix-2 divider, the inverse of the team's 16x16 sequential

---
 rtl/seq_divider.sv | 195 +++++++++++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Sequential signed radix-2 restoring divider. It is the counterpart of the
//   16x16 sequential multiplier. It divides a DW-bit dividend by a VW-bit
//   divisor, producing one quotient bit per clock, then fixes up the signs.
//   Quotient truncates toward zero. Remainder takes the sign of the dividend.
//
// Ports
//   clk    in   1    rising-edge clock
//   rst    in   1    asynchronous active-low reset
//   start  in   1    request, sampled only while ready=1
//   A      in   DW   signed dividend, captured on accepted start
//   B      in   VW   signed divisor, captured on accepted start
//   ready  out  1    idle, a new start will be accepted
//   valid  out  1    one-cycle pulse, Q/R/dbz/ovf are final
//   Q      out  DW   signed quotient
//   R      out  VW   signed remainder
//   dbz    out  1    divide-by-zero flag for the current result
//   ovf    out  1    overflow flag (A = -2^(DW-1), B = -1)
// ---------------------------------------------------------------------------
module seq_divider #(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] A,
   input  logic [VW-1:0] B,
   output logic          ready,
   output logic          valid,
   output logic [DW-1:0] Q,
   output logic [VW-1:0] R,
   output logic          dbz,
   output logic          ovf
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   // LOAD sits between the accept edge and CALC. Raw operands are captured
   // first, and their magnitudes are formed from the registered copies.
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] a_q, a_d;
   logic [VW-1:0] b_q, b_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [VW:0]   rem_q, rem_d;
   logic [VW:0]   div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW-1:0] r_q, r_d;
   logic          dbz_q, dbz_d;
   logic          ovf_q, ovf_d;
   logic          ready_q, ready_d;
   logic          valid_q, valid_d;

   logic [VW:0]   trial;
   logic          fits;
   logic          a_neg;
   logic          b_neg;

   // quo_q starts as |A| and shifts left. Each cycle its MSB feeds the partial
   // remainder, and the new quotient bit enters at the LSB. |B| can be as large
   // as 2^(VW-1), so the divisor and remainder paths are VW+1 bits wide.
   always_comb begin
      trial = {rem_q[VW-1:0], quo_q[DW-1]};
      fits  = (trial >= div_q);
      a_neg = a_q[DW-1];
      b_neg = b_q[VW-1];
   end

   // Next-state and datapath. The result registers are written only in LOAD
   // (divide by zero) and FIX. They hold their values until the next result.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               dbz_d   = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            if (b_q == '0) begin
               q_d     = '1;
               r_d     = a_q[VW-1:0];
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               quo_d   = a_neg ? -a_q : a_q;
               div_d   = b_neg ? -{b_q[VW-1], b_q} : {1'b0, b_q};
               rem_d   = '0;
               cnt_d   = CW'(DW - 1);
               state_d = S_CALC;
            end
         end

         S_CALC: begin
            rem_d = fits ? (trial - div_q) : trial;
            quo_d = {quo_q[DW-2:0], fits};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            q_d = (a_neg ^ b_neg) ? -quo_q : quo_q;
            r_d = a_neg ? -rem_q[VW-1:0] : rem_q[VW-1:0];
            // The true quotient 2^(DW-1) does not fit, so it wraps to the
            // most negative value.
            if ((a_q == MOST_NEG) && (b_q == '1)) begin
               q_d   = MOST_NEG;
               ovf_d = 1'b1;
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_DONE);
   end

   // All state and outputs live in these flops. A reset discards any
   // operation in flight, and no valid pulse is produced for it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign ready = ready_q;
   assign valid = valid_q;
   assign Q     = q_q;
   assign R     = r_q;
   assign dbz   = dbz_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Directed and random checks of seq_divider. Expected values come from
//   hand-computed vectors, from a multiplier model (A = X*Y gives Q = X, R = 0),
//   or from native signed 64-bit division, which truncates toward zero.
// ---------------------------------------------------------------------------
module tb_seq_divider;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] A;
   logic [15:0] B;
   logic        ready;
   logic        valid;
   logic [31:0] Q;
   logic [15:0] R;
   logic        dbz;
   logic        ovf;

   int checkCount = 0;
   int errorCount = 0;

   seq_divider #(.DW(32), .VW(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .ready (ready),
      .valid (valid),
      .Q     (Q),
      .R     (R),
      .dbz   (dbz),
      .ovf   (ovf)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison, and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Run one division and check its result, flags, latency and pulse shape.
   // Inputs are driven on the falling edge, and outputs are sampled there.
   task automatic applyStimulus(input string tag, input logic [31:0] a,
                                input logic [15:0] b, input bit pulseMid,
                                input logic [31:0] expQ, input logic [15:0] expR,
                                input logic expDbz, input logic expOvf);
      int cycles;
      int expLat;
      bit seen;
      expLat = (b == 16'd0) ? 1 : 34;
      cycles = 0;
      while (!ready && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, ".readyWait"}, 64'(ready), 64'd1);
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = 32'h5A5A_5A5A;
      B     = 16'hA5A5;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (valid) begin
            seen = 1'b1;
         end else if (pulseMid && cycles == 5) begin
            start = 1'b1;
         end else if (pulseMid && cycles == 6) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      checkOutput({tag, ".validSeen"}, 64'(seen), 64'd1);
      checkOutput({tag, ".latency"}, 64'(cycles - 1), 64'(expLat));
      checkOutput({tag, ".Q"}, 64'(Q), 64'(expQ));
      checkOutput({tag, ".R"}, 64'(R), 64'(expR));
      checkOutput({tag, ".dbz"}, 64'(dbz), 64'(expDbz));
      checkOutput({tag, ".ovf"}, 64'(ovf), 64'(expOvf));
      checkOutput({tag, ".readyInDone"}, 64'(ready), 64'd0);
      @(negedge clk);
      checkOutput({tag, ".pulseEnd"}, 64'({valid, ready}), 64'b01);
      checkOutput({tag, ".hold"}, 64'({Q, R}), 64'({expQ, expR}));
   endtask

   initial begin
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [31:0] ra;
      longint             prod;
      longint             qm;
      longint             rm;
      int                 validCount;
      int                 absR;
      int                 absB;

      rst   = 1'b0;
      start = 1'b0;
      A     = 32'd0;
      B     = 16'd0;
      #12;
      checkOutput("reset.outputs", 64'({ready, valid, dbz, ovf}), 64'b1000);
      checkOutput("reset.QR", 64'({Q, R}), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      applyStimulus("pp", 32'd100, 16'd7, 1'b0, 32'd14, 16'd2, 1'b0, 1'b0);
      applyStimulus("np", -32'sd100, 16'd7, 1'b0, -32'sd14, -16'sd2, 1'b0, 1'b0);
      applyStimulus("pn", 32'd100, -16'sd7, 1'b0, -32'sd14, 16'd2, 1'b0, 1'b0);
      applyStimulus("nn", -32'sd100, -16'sd7, 1'b0, 32'd14, -16'sd2, 1'b0, 1'b0);
      applyStimulus("sq", 32'd1073676289, -16'sd32767, 1'b0, -32'sd32767, 16'd0, 1'b0, 1'b0);
      applyStimulus("bmin", 32'h3FFF_FFFF, 16'h8000, 1'b0, -32'sd32767, 16'd32767, 1'b0, 1'b0);
      applyStimulus("dbz", 32'd12345, 16'd0, 1'b0, 32'hFFFF_FFFF, 16'd12345, 1'b1, 1'b0);
      applyStimulus("ovf", 32'h8000_0000, 16'hFFFF, 1'b0, 32'h8000_0000, 16'd0, 1'b0, 1'b1);
      applyStimulus("afterOvf", -32'sd7, 16'd2, 1'b0, -32'sd3, -16'sd1, 1'b0, 1'b0);
      applyStimulus("midStart", 32'd1000, 16'd33, 1'b1, 32'd30, 16'd10, 1'b0, 1'b0);

      // Assert reset asynchronously partway through CALC.
      @(negedge clk);
      A     = 32'd50000;
      B     = 16'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midReset.outputs", 64'({ready, valid, dbz, ovf}), 64'b1000);
      checkOutput("midReset.QR", 64'({Q, R}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      validCount = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) validCount++;
      end
      checkOutput("midReset.noValid", 64'(validCount), 64'd0);
      applyStimulus("postReset", 32'd50, 16'd5, 1'b0, 32'd10, 16'd0, 1'b0, 1'b0);

      // Multiplier model: A = X*Y, so Q must be X and R must be 0.
      for (int i = 0; i < 200; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         if (y == 16'sd0) y = 16'sd1;
         prod = longint'(x) * longint'(y);
         applyStimulus("mul", 32'(prod), y, 1'b0, 32'(longint'(x)), 16'd0, 1'b0, 1'b0);
      end

      // Random operands checked against native truncating division.
      for (int i = 0; i < 100; i++) begin
         ra = 32'($urandom);
         y  = 16'($urandom);
         if (i % 4 == 0) y = 16'(y % 16'sd200);
         if (y == 16'sd0) y = -16'sd3;
         if (ra == 32'sh8000_0000 && y == -16'sd1) y = 16'sd2;
         qm = longint'(ra) / longint'(y);
         rm = longint'(ra) % longint'(y);
         applyStimulus("rnd", ra, y, 1'b0, 32'(qm), 16'(rm), 1'b0, 1'b0);
         absR = (R[15]) ? -int'($signed(R)) : int'(R);
         absB = (y < 0) ? -int'(y) : int'(y);
         checkOutput("rnd.absR", 64'(absR < absB), 64'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
